// File: rtl/phy_mgmt_ctrl.sv
// phy_mgmt_ctrl: sequences PHY register accesses through an MDIO master (init table, host access, link poll).
// Link polling of reg 0x01 is compiled in only when PHY_LINK_POLL_EN is defined.
module phy_mgmt_ctrl #(
    parameter logic [4:0] PHY_ADDR      = 5'h01,
    parameter int         POLL_INTERVAL = 100000,
    parameter int         TIMEOUT       = 4096
) (
    input  logic        sys_clk_100m,
    input  logic        sys_rst_n,
    input  logic        i_host_req,
    input  logic [1:0]  i_host_op,
    input  logic [4:0]  i_host_reg,
    input  logic [15:0] i_host_wdata,
    output logic        o_host_ack,
    output logic [15:0] o_host_rdata,
    output logic [1:0]  o_operation,
    output logic [4:0]  o_phy_addr,
    output logic [4:0]  o_reg_addr,
    output logic [15:0] o_write_data,
    output logic        o_operation_begin,
    input  logic [15:0] i_read_data,
    input  logic        i_read_data_valid,
    input  logic        i_operation_finish,
    input  logic        i_master_busy,
    output logic        o_init_done,
    output logic        o_link_up,
    output logic        o_link_change,
    output logic        o_timeout_err
);
    typedef enum logic [2:0] {IDLE, INIT_ISSUE, ARB, ISSUE, WAIT_DONE, GAP} state_t;
    typedef enum logic [1:0] {K_INIT, K_HOST, K_POLL} kind_t;

    // One counter serves the post-reset delay, the begin width, the timeout and the gap
    localparam int CW = $clog2((TIMEOUT > 16) ? TIMEOUT : 16) + 1;

    state_t        state;
    kind_t         kind;
    logic [CW-1:0] cnt;
    logic [1:0]    init_idx;
    logic [15:0]   rd_lat;
    logic [4:0]    init_reg;
    logic [15:0]   init_data;
    logic [15:0]   rd_now;
    logic          timed_out;
    logic          done;
    logic          host_sel;
    logic          host_ok;

    // Init table lookup, completion detection and host request qualification
    always_comb begin
        init_reg  = (init_idx == 2'd1) ? 5'h04 : 5'h00;
        init_data = (init_idx == 2'd0) ? 16'h8000 : (init_idx == 2'd1) ? 16'h01E1 : 16'h1200;
        rd_now    = i_read_data_valid ? i_read_data : rd_lat;
        timed_out = (state == WAIT_DONE) && !i_operation_finish && (cnt == CW'(TIMEOUT - 1));
        done      = (state == WAIT_DONE) && (i_operation_finish || timed_out);
        host_sel  = (state == ARB) && o_init_done && i_host_req;
        host_ok   = (i_host_op == 2'b01) || (i_host_op == 2'b10);
    end

`ifdef PHY_LINK_POLL_EN
    localparam int PW = $clog2(POLL_INTERVAL + 1);
    logic [PW-1:0] poll_cnt;
    logic          poll_go;

    assign poll_go = (state == ARB) && o_init_done && !i_host_req && (poll_cnt == PW'(POLL_INTERVAL));

    // Poll interval counter: runs after init, saturates at the interval (poll due), clears when a poll issues
    always_ff @(posedge sys_clk_100m or negedge sys_rst_n)
        if (!sys_rst_n) poll_cnt <= '0;
        else if (poll_go) poll_cnt <= '0;
        else if (o_init_done && poll_cnt != PW'(POLL_INTERVAL)) poll_cnt <= poll_cnt + PW'(1);

    // Link status from completed polls; a timed-out poll keeps the previous status
    always_ff @(posedge sys_clk_100m or negedge sys_rst_n)
        if (!sys_rst_n) begin
            o_link_up     <= 1'b0;
            o_link_change <= 1'b0;
        end else begin
            o_link_change <= 1'b0;
            if (done && kind == K_POLL && !timed_out) begin
                o_link_up     <= rd_now[2];
                o_link_change <= rd_now[2] != o_link_up;
            end
        end
`else
    assign o_link_up     = 1'b0;
    assign o_link_change = 1'b0;
`endif

    // Transaction sequencer: init table, arbitration, issue with a 2-cycle begin, completion and gap
    always_ff @(posedge sys_clk_100m or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state             <= IDLE;
            kind              <= K_INIT;
            cnt               <= '0;
            init_idx          <= 2'd0;
            rd_lat            <= 16'h0000;
            o_host_ack        <= 1'b0;
            o_host_rdata      <= 16'h0000;
            o_operation       <= 2'b00;
            o_phy_addr        <= 5'h00;
            o_reg_addr        <= 5'h00;
            o_write_data      <= 16'h0000;
            o_operation_begin <= 1'b0;
            o_init_done       <= 1'b0;
            o_timeout_err     <= 1'b0;
        end else begin
            o_host_ack <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(15)) begin
                        cnt   <= '0;
                        state <= INIT_ISSUE;
                    end
                end
                INIT_ISSUE: begin
                    kind         <= K_INIT;
                    o_operation  <= 2'b01;
                    o_phy_addr   <= PHY_ADDR;
                    o_reg_addr   <= init_reg;
                    o_write_data <= init_data;
                    state        <= ISSUE;
                end
                ARB: begin
                    if (host_sel) begin
                        kind <= K_HOST;
                        if (host_ok) begin
                            o_operation  <= i_host_op;
                            o_phy_addr   <= PHY_ADDR;
                            o_reg_addr   <= i_host_reg;
                            o_write_data <= (i_host_op == 2'b10) ? 16'h0000 : i_host_wdata;
                            state        <= ISSUE;
                        end else begin
                            o_host_ack <= 1'b1;
                            cnt        <= '0;
                            state      <= GAP;
                        end
                    end
`ifdef PHY_LINK_POLL_EN
                    else if (poll_go) begin
                        kind         <= K_POLL;
                        o_operation  <= 2'b10;
                        o_phy_addr   <= PHY_ADDR;
                        o_reg_addr   <= 5'h01;
                        o_write_data <= 16'h0000;
                        state        <= ISSUE;
                    end
`endif
                end
                ISSUE: begin
                    if (!i_master_busy) begin
                        o_operation_begin <= 1'b1;
                        cnt               <= '0;
                        rd_lat            <= 16'h0000;
                        state             <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(1)) o_operation_begin <= 1'b0;
                    if (i_read_data_valid) rd_lat <= i_read_data;
                    if (done) begin
                        o_operation_begin <= 1'b0;
                        cnt               <= '0;
                        state             <= GAP;
                        if (timed_out) o_timeout_err <= 1'b1;
                        if (kind == K_INIT) init_idx <= init_idx + 2'd1;
                        if (kind == K_HOST) begin
                            o_host_ack   <= 1'b1;
                            o_host_rdata <= timed_out ? 16'hFFFF : (o_operation == 2'b10) ? rd_now : o_host_rdata;
                        end
                    end
                end
                GAP: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(3)) begin
                        cnt <= '0;
                        if (kind == K_INIT && init_idx != 2'd3) state <= INIT_ISSUE;
                        else state <= ARB;
                        if (kind == K_INIT && init_idx == 2'd3) o_init_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/phy_mgmt_ctrl.md
PHY_MGMT_CTRL -- requirements
Module: phy_mgmt_ctrl

Interface
REQ-001 SHALL provide: sys_clk_100m  in  1  system clock, 100 MHz.
REQ-002 SHALL provide: sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: i_host_req  in  1, i_host_op  in  2 (01 write, 10 read), i_host_reg  in  5, i_host_wdata  in  16: host register-access request, held until o_host_ack.
REQ-004 SHALL provide: o_host_ack  out  1 (one-cycle pulse, transaction complete), o_host_rdata  out  16 (read result, valid with ack).
REQ-005 SHALL provide, to the MDIO master: o_operation  out  2, o_phy_addr  out  5, o_reg_addr  out  5, o_write_data  out  16, o_operation_begin  out  1.
REQ-006 SHALL provide, from the MDIO master: i_read_data  in  16, i_read_data_valid  in  1, i_operation_finish  in  1, i_master_busy  in  1.
REQ-007 SHALL provide: o_init_done  out  1, o_link_up  out  1, o_link_change  out  1 (pulse), o_timeout_err  out  1 (sticky).
REQ-008 SHALL provide parameters: PHY_ADDR, default 5'h01, target PHY address; POLL_INTERVAL, default 100000, cycles between link polls (1 ms); TIMEOUT, default 4096, cycles allowed per transaction.

Function
REQ-009 SHALL run a fixed init table after reset, in order: reg 0x00 <- 16'h8000; reg 0x04 <- 16'h01E1; reg 0x00 <- 16'h1200.
REQ-010 SHALL use states IDLE, INIT_ISSUE, ARB, ISSUE, WAIT_DONE, GAP. Reset state is IDLE; IDLE moves to INIT_ISSUE 16 cycles after reset release.
REQ-011 SHALL, on issue, drive o_operation/o_phy_addr/o_reg_addr/o_write_data stable, then assert o_operation_begin high for exactly 2 cycles. Fields SHALL stay stable until i_operation_finish.
REQ-012 SHALL drive o_write_data to 16'h0000 for reads.
REQ-013 SHALL, in WAIT_DONE, latch i_read_data when i_read_data_valid is high, and leave WAIT_DONE on i_operation_finish.
REQ-014 SHALL spend 4 cycles in GAP with o_operation_begin low after every transaction, so the master sees a fresh rising edge and has returned to idle.
REQ-015 SHALL set o_init_done high on the GAP exit that follows the third init entry; it then stays high until reset.
REQ-016 SHALL, in ARB (only when o_init_done=1): host request first; else a due link poll; else stay in ARB.
REQ-017 SHALL, for a host request, issue i_host_op/i_host_reg/i_host_wdata; on finish, pulse o_host_ack for 1 cycle with o_host_rdata set to the latched data (reads) or unchanged (writes).
REQ-018 SHALL not accept host requests with i_host_op other than 01 or 10: ack for 1 cycle, no MDIO transaction, o_host_rdata unchanged.
REQ-019 SHALL keep host requests pending during init; they are served in the first ARB after init.
REQ-020 SHALL, while in WAIT_DONE, count cycles; reaching TIMEOUT without finish SHALL set o_timeout_err, drop begin, go to GAP; a host transaction that times out SHALL still ack, with o_host_rdata=16'hFFFF.
REQ-021 SHALL, on a timed-out init entry, go on to the next entry.
REQ-022 SHALL not issue o_operation_begin while i_master_busy=1; ISSUE waits for busy=0.
REQ-023 SHALL use a poll interval counter that runs freely after o_init_done, saturates at POLL_INTERVAL and sets "poll due". It SHALL clear when a poll issues.

Reset
REQ-024 SHALL, on sys_rst_n low, force immediately: state IDLE; all outputs 0 (o_operation 2'b00, o_phy_addr 0, o_reg_addr 0, o_write_data 0, o_host_rdata 0); counters 0; poll-due clear.
REQ-025 SHALL, on reset mid-transaction, abandon the transaction with no ack and restart init after release.

Configuration
REQ-026 SHALL, with PHY_LINK_POLL_EN defined, poll (read) reg 0x01 when due; o_link_up <= bit 2 of the read data. A change in o_link_up SHALL pulse o_link_change for 1 cycle. A timed-out poll SHALL leave o_link_up unchanged.
REQ-027 SHALL, without PHY_LINK_POLL_EN, exclude the poll counter and poll path: ARB serves only host requests, and o_link_up and o_link_change are tied to 0.

Verification
REQ-028 SHALL cover: release reset with a master model finishing in 1300 cycles -> three writes (0x00/8000, 0x04/01E1, 0x00/1200), each with a 2-cycle begin, then o_init_done=1.
REQ-029 SHALL cover: host read of reg 0x02, model returns 16'h0141 -> MDIO read issued to PHY_ADDR/0x02, o_host_ack pulse, o_host_rdata=16'h0141.
REQ-030 SHALL cover, with PHY_LINK_POLL_EN and POLL_INTERVAL=2000: model returns 0x796D, then 0x7969 -> o_link_up goes 1 then 0, with a one-cycle o_link_change pulse at each change.
REQ-031 SHALL cover: model never asserts finish, TIMEOUT=4096, on a host write -> ack after 4096 cycles, o_host_rdata=FFFF, o_timeout_err=1 until reset.
REQ-032 SHALL cover: host request held during init, with poll due at the same time -> host served first after init, poll next; i_host_op=2'b11 -> ack with no begin pulse.
REQ-033 SHALL cover: reset asserted mid-WAIT_DONE -> all outputs 0 at once, no ack, init restarts after release.
